alu_ctrl_muldiv: RTL and testbench

ALU_CTRL_MULDIV -- requirements
Module: alu_ctrl_muldiv

---
 rtl/alu_ctrl_pkg.sv | 59 +++++
 rtl/muldiv_iter.sv | 138 +++++++++++++
 rtl/alu_ctrl_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control / multiply-divide block.
// The DIV state exists only when ALU_DIV_EN is defined.
package alu_ctrl_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ORI   = 2'b11;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   localparam logic [3:0] CTR_AND  = 4'b0000;
   localparam logic [3:0] CTR_OR   = 4'b0001;
   localparam logic [3:0] CTR_ADD  = 4'b0010;
   localparam logic [3:0] CTR_XOR  = 4'b0011;
   localparam logic [3:0] CTR_SUB  = 4'b0110;
   localparam logic [3:0] CTR_SLT  = 4'b0111;
   localparam logic [3:0] CTR_SLTU = 4'b1000;
   localparam logic [3:0] CTR_NOR  = 4'b1100;
   localparam logic [3:0] CTR_ILL  = 4'b1111;

`ifdef ALU_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd3} state_e;
`endif

   // Instructions that touch HI/LO and therefore must wait while the unit is busy.
   function automatic logic is_md_group(input logic [5:0] fn);
      logic hit;
      hit = 1'b0;
      case (fn)
         FN_MULT, FN_MULTU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: hit = 1'b1;
`ifdef ALU_DIV_EN
         FN_DIV, FN_DIVU: hit = 1'b1;
`endif
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiplier and (with ALU_DIV_EN) restoring divider on magnitudes.
// res_hi/res_lo show the sign-corrected result of the step being taken this cycle.
import alu_ctrl_pkg::*;

module muldiv_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
`ifdef ALU_DIV_EN
   input  logic              op_div,
   output logic              res_divz,
`endif
   input  logic              op_signed,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo
);

   logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic              neg_q, neg_d;
   logic [DATA_W-1:0] acc_hi_n, acc_lo_n;
   logic [DATA_W-1:0] a_mag, b_mag;
   logic              a_neg, b_neg;
   logic [DATA_W:0]   mul_sum;
   logic [2*DATA_W-1:0] prod, prod_fix;
`ifdef ALU_DIV_EN
   logic              div_q, div_d, rem_neg_q, rem_neg_d, zero_q, zero_d;
   logic [DATA_W-1:0] a_raw_q, a_raw_d;
   logic [DATA_W:0]   shifted, trial;
`endif

   always_comb begin
      a_neg    = op_signed & op_a[DATA_W-1];
      b_neg    = op_signed & op_b[DATA_W-1];
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;

      // Multiply step: conditionally add multiplicand into the upper half, shift the pair right.
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
      acc_hi_n = acc_hi_q;
      acc_lo_n = acc_lo_q;
`ifdef ALU_DIV_EN
      shifted  = {acc_hi_q, acc_lo_q[DATA_W-1]};
      trial    = shifted - {1'b0, mcand_q};
`endif
      if (step) begin
`ifdef ALU_DIV_EN
         if (div_q) begin
            acc_hi_n = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
            acc_lo_n = {acc_lo_q[DATA_W-2:0], ~trial[DATA_W]};
         end else begin
            acc_hi_n = mul_sum[DATA_W:1];
            acc_lo_n = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
         end
`else
         acc_hi_n = mul_sum[DATA_W:1];
         acc_lo_n = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
`endif
      end

      prod     = {acc_hi_n, acc_lo_n};
      prod_fix = neg_q ? -prod : prod;
      res_hi   = prod_fix[2*DATA_W-1:DATA_W];
      res_lo   = prod_fix[DATA_W-1:0];
`ifdef ALU_DIV_EN
      res_divz = zero_q;
      if (div_q) begin
         if (zero_q) begin
            res_lo = '1;
            res_hi = a_raw_q;
         end else begin
            res_lo = neg_q ? -acc_lo_n : acc_lo_n;
            res_hi = rem_neg_q ? -acc_hi_n : acc_hi_n;
         end
      end
`endif
   end

   always_comb begin
      acc_hi_d = acc_hi_n;
      acc_lo_d = acc_lo_n;
      mcand_d  = mcand_q;
      neg_d    = neg_q;
`ifdef ALU_DIV_EN
      div_d     = div_q;
      rem_neg_d = rem_neg_q;
      zero_d    = zero_q;
      a_raw_d   = a_raw_q;
`endif
      if (start) begin
         acc_hi_d = '0;
         neg_d    = a_neg ^ b_neg;
`ifdef ALU_DIV_EN
         div_d     = op_div;
         rem_neg_d = a_neg;
         zero_d    = op_div & (op_b == '0);
         a_raw_d   = op_a;
         acc_lo_d  = op_div ? a_mag : b_mag;
         mcand_d   = op_div ? b_mag : a_mag;
`else
         acc_lo_d  = b_mag;
         mcand_d   = a_mag;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
`ifdef ALU_DIV_EN
         div_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         zero_q    <= 1'b0;
         a_raw_q   <= '0;
`endif
      end else begin
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mcand_q  <= mcand_d;
         neg_q    <= neg_d;
`ifdef ALU_DIV_EN
         div_q     <= div_d;
         rem_neg_q <= rem_neg_d;
         zero_q    <= zero_d;
         a_raw_q   <= a_raw_d;
`endif
      end
   end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Define ALU_DIV_EN to include div/divu; otherwise they decode as illegal.
import alu_ctrl_pkg::*;

// state | meaning
// IDLE  | accepts ALU, mult/div and HI/LO move instructions
// MUL   | multiply iterations, counter DATA_W-1 down to 0
// DIV   | divide iterations, counter DATA_W-1 down to 0 (ALU_DIV_EN only)
// FIN   | hi/lo just written; done (and divz) asserted for this one cycle
module alu_ctrl_muldiv #(
   parameter int DATA_W = 32,
   parameter int CTR_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        aluOp,
   input  logic [5:0]        funct,
   input  logic              valid,
   input  logic [DATA_W-1:0] srcA,
   input  logic [DATA_W-1:0] srcB,
   output logic [CTR_W-1:0]  aluCtr,
   output logic              illegal,
   output logic              stall,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] mdOut,
   output logic              done,
   output logic              divz
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              busy_q, busy_d;
   logic [3:0]        ctr;
   logic              is_mul_op, is_mfhi, is_mflo, is_mthi, is_mtlo, md_signed;
   logic              start, step;
   logic [DATA_W-1:0] res_hi, res_lo;
`ifdef ALU_DIV_EN
   logic              is_div_op, divz_q, divz_d, res_divz;
`endif

   always_comb begin
      ctr       = CTR_ILL;
      illegal   = 1'b0;
      is_mul_op = 1'b0;
      is_mfhi   = 1'b0;
      is_mflo   = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
`ifdef ALU_DIV_EN
      is_div_op = 1'b0;
`endif
      md_signed = ~funct[0];
      case (aluOp)
         ALUOP_ADD: ctr = CTR_ADD;
         ALUOP_SUB: ctr = CTR_SUB;
         ALUOP_ORI: ctr = CTR_OR;
         default: begin
            case (funct)
               FN_ADD, FN_ADDU:   ctr = CTR_ADD;
               FN_SUB, FN_SUBU:   ctr = CTR_SUB;
               FN_AND:            ctr = CTR_AND;
               FN_OR:             ctr = CTR_OR;
               FN_XOR:            ctr = CTR_XOR;
               FN_NOR:            ctr = CTR_NOR;
               FN_SLT:            ctr = CTR_SLT;
               FN_SLTU:           ctr = CTR_SLTU;
               FN_MULT, FN_MULTU: begin ctr = CTR_ADD; is_mul_op = 1'b1; end
`ifdef ALU_DIV_EN
               FN_DIV, FN_DIVU:   begin ctr = CTR_ADD; is_div_op = 1'b1; end
`endif
               FN_MFHI:           begin ctr = CTR_ADD; is_mfhi = 1'b1; end
               FN_MFLO:           begin ctr = CTR_ADD; is_mflo = 1'b1; end
               FN_MTHI:           begin ctr = CTR_ADD; is_mthi = 1'b1; end
               FN_MTLO:           begin ctr = CTR_ADD; is_mtlo = 1'b1; end
               default:           begin ctr = CTR_ILL; illegal = 1'b1; end
            endcase
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      start   = 1'b0;
      step    = 1'b0;
`ifdef ALU_DIV_EN
      divz_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (valid) begin
               if (is_mul_op) begin
                  state_d = MUL;
                  cnt_d   = CNT_LAST;
                  start   = 1'b1;
`ifdef ALU_DIV_EN
               end else if (is_div_op) begin
                  state_d = DIV;
                  cnt_d   = CNT_LAST;
                  start   = 1'b1;
`endif
               end else if (is_mthi) begin
                  hi_d = srcA;
               end else if (is_mtlo) begin
                  lo_d = srcA;
               end
            end
         end
`ifdef ALU_DIV_EN
         MUL, DIV: begin
`else
         MUL: begin
`endif
            step = 1'b1;
            if (cnt_q == '0) begin
               state_d = FIN;
               hi_d    = res_hi;
               lo_d    = res_lo;
`ifdef ALU_DIV_EN
               divz_d  = res_divz;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
`ifdef ALU_DIV_EN
         divz_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
`ifdef ALU_DIV_EN
         divz_q  <= divz_d;
`endif
      end
   end

   muldiv_iter #(.DATA_W(DATA_W)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
`ifdef ALU_DIV_EN
      .op_div    (is_div_op),
      .res_divz  (res_divz),
`endif
      .op_signed (md_signed),
      .op_a      (srcA),
      .op_b      (srcB),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   assign aluCtr = CTR_W'(ctr);
   assign stall  = valid & busy_q & (aluOp == ALUOP_RTYPE) & is_md_group(funct);
   assign busy   = busy_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign mdOut  = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
   assign done   = (state_q == FIN);
`ifdef ALU_DIV_EN
   assign divz   = divz_q;
`else
   assign divz   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomized bench for alu_ctrl_muldiv against a cycle-countdown reference model.
// Follows ALU_DIV_EN the same way as the design.
module tb_alu_ctrl_muldiv;

   localparam int W = 32;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                          F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                          F_DIV = 6'b011010, F_DIVU = 6'b011011;

   logic          clk = 1'b0;
   logic          rst_n, valid, illegal, stall, busy, done, divz;
   logic [1:0]    aluOp;
   logic [5:0]    funct;
   logic [W-1:0]  srcA, srcB, hi, lo, mdOut;
   logic [3:0]    aluCtr;

   int            vectors = 0;
   int            miscompares = 0;

   int            rem;
   logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
   logic          p_divz;
   logic [3:0]    ctr_tab [logic [5:0]];
   bit            md_grp  [logic [5:0]];
   logic          s_done, s_stall, s_divz;
   logic [W-1:0]  s_mdout;
   logic [5:0]    fn_list [18];

   alu_ctrl_muldiv #(.DATA_W(W), .CTR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .aluOp(aluOp), .funct(funct), .valid(valid),
      .srcA(srcA), .srcB(srcB), .aluCtr(aluCtr), .illegal(illegal), .stall(stall),
      .busy(busy), .hi(hi), .lo(lo), .mdOut(mdOut), .done(done), .divz(divz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic [3:0]   e_ctr;
      logic         e_ill, e_stall;
      logic [W-1:0] e_md;
      vectors++;
      if (aluOp == 2'b10) begin
         if (ctr_tab.exists(funct)) begin e_ctr = ctr_tab[funct]; e_ill = 1'b0; end
         else begin e_ctr = 4'hF; e_ill = 1'b1; end
      end else begin
         e_ill = 1'b0;
         e_ctr = (aluOp == 2'b00) ? 4'h2 : ((aluOp == 2'b01) ? 4'h6 : 4'h1);
      end
      e_stall = valid && (rem != 0) && (aluOp == 2'b10) && md_grp.exists(funct);
      e_md = '0;
      if (aluOp == 2'b10 && funct == F_MFHI) e_md = m_hi;
      if (aluOp == 2'b10 && funct == F_MFLO) e_md = m_lo;
      chk("aluCtr",  64'(aluCtr),  64'(e_ctr));
      chk("illegal", 64'(illegal), 64'(e_ill));
      chk("stall",   64'(stall),   64'(e_stall));
      chk("busy",    64'(busy),    64'(rem != 0));
      chk("done",    64'(done),    64'(rem == 1));
      chk("divz",    64'(divz),    64'((rem == 1) && p_divz));
      chk("hi",      64'(hi),      64'(m_hi));
      chk("lo",      64'(lo),      64'(m_lo));
      chk("mdOut",   64'(mdOut),   64'(e_md));
      s_done = done; s_stall = stall; s_divz = divz; s_mdout = mdOut;
   endtask

   task automatic model_step();
      longint       sa, sb;
      logic [63:0]  prod;
      int           qa, qb;
      if (!rst_n) begin
         rem = 0; m_hi = '0; m_lo = '0; p_divz = 1'b0;
         return;
      end
      if (rem != 0) begin
         if (rem == 2) begin m_hi = p_hi; m_lo = p_lo; end
         rem--;
      end else if (valid && aluOp == 2'b10) begin
         case (funct)
            F_MULT: begin
               sa = longint'($signed(srcA)); sb = longint'($signed(srcB));
               prod = 64'(sa * sb);
               p_hi = prod[63:32]; p_lo = prod[31:0]; p_divz = 1'b0; rem = W + 1;
            end
            F_MULTU: begin
               prod = {32'b0, srcA} * {32'b0, srcB};
               p_hi = prod[63:32]; p_lo = prod[31:0]; p_divz = 1'b0; rem = W + 1;
            end
`ifdef ALU_DIV_EN
            F_DIV: begin
               rem = W + 1; p_divz = 1'b0;
               if (srcB == 0) begin p_lo = '1; p_hi = srcA; p_divz = 1'b1; end
               else if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
                  p_lo = 32'h8000_0000; p_hi = '0;
               end else begin
                  qa = $signed(srcA); qb = $signed(srcB);
                  p_lo = qa / qb; p_hi = qa % qb;
               end
            end
            F_DIVU: begin
               rem = W + 1; p_divz = 1'b0;
               if (srcB == 0) begin p_lo = '1; p_hi = srcA; p_divz = 1'b1; end
               else begin p_lo = srcA / srcB; p_hi = srcA % srcB; end
            end
`endif
            F_MTHI: m_hi = srcA;
            F_MTLO: m_lo = srcA;
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic r, input logic [1:0] op, input logic [5:0] fn,
                        input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit do_cmp);
      @(negedge clk);
      rst_n = r; aluOp = op; funct = fn; valid = v; srcA = a; srcB = b;
      #1;
      if (do_cmp) compare();
      @(posedge clk);
      model_step();
   endtask

   task automatic idle();
      cycle(1'b1, 2'b00, 6'd0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
      cycle(1'b1, 2'b10, fn, 1'b1, a, b, 1'b1);
   endtask

   // Runs idle cycles until done is seen; returns the cycle count since the accept.
   task automatic wait_done(output int n);
      n = 0;
      s_done = 1'b0;
      while (!s_done && n < 40) begin
         n++;
         idle();
      end
      if (!s_done) begin
         miscompares++;
         $display("FAIL wait_done: no done within %0d cycles", n);
      end
   endtask

   function automatic logic [W-1:0] rnd_opnd();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n, k, dcount;
      logic [5:0] fn;

      ctr_tab[6'b100000] = 4'b0010; ctr_tab[6'b100001] = 4'b0010;
      ctr_tab[6'b100010] = 4'b0110; ctr_tab[6'b100011] = 4'b0110;
      ctr_tab[6'b100100] = 4'b0000; ctr_tab[6'b100101] = 4'b0001;
      ctr_tab[6'b100110] = 4'b0011; ctr_tab[6'b100111] = 4'b1100;
      ctr_tab[6'b101010] = 4'b0111; ctr_tab[6'b101011] = 4'b1000;
      foreach (fn_list[i]) fn_list[i] = '0;
      fn_list = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b101011, F_MULT, F_MULTU,
                  F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
      for (int i = 10; i < 18; i++) begin
`ifndef ALU_DIV_EN
         if (fn_list[i] == F_DIV || fn_list[i] == F_DIVU) continue;
`endif
         ctr_tab[fn_list[i]] = 4'b0010;
         md_grp[fn_list[i]]  = 1'b1;
      end
      rem = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_divz = 1'b0;
      s_done = 0; s_stall = 0; s_divz = 0; s_mdout = '0;

      cycle(1'b0, 2'b00, 6'd0, 1'b0, '0, '0, 1'b0);
      cycle(1'b0, 2'b00, 6'd0, 1'b0, '0, '0, 1'b1);
      #1;
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      idle();
      #1 chk("stall_after_reset", 64'(stall), 64'd0);

      cycle(1'b1, 2'b10, 6'b100111, 1'b0, '0, '0, 1'b1);
      #1;
      chk("nor_ctr", 64'(aluCtr), 64'hC);
      chk("nor_illegal", 64'(illegal), 64'd0);
      cycle(1'b1, 2'b10, 6'b111111, 1'b0, '0, '0, 1'b1);
      #1;
      chk("bad_ctr", 64'(aluCtr), 64'hF);
      chk("bad_illegal", 64'(illegal), 64'd1);

      md(F_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(n);
      #1;
      chk("mult_latency", 64'(n), 64'd33);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
      idle();

`ifdef ALU_DIV_EN
      md(F_DIVU, 32'd100, 32'd7);
      wait_done(n);
      #1;
      chk("divu_lo", 64'(lo), 64'd14);
      chk("divu_hi", 64'(hi), 64'd2);
      idle();
      md(F_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      #1;
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
      idle();
      md(F_DIV, 32'd5, 32'd0);
      wait_done(n);
      #1;
      chk("divz_flag", 64'(s_divz), 64'd1);
      chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("divz_hi", 64'(hi), 64'd5);
      idle();
`endif

      md(F_MULTU, 32'd5, 32'd9);
      idle();
      idle();
      k = 2;
      do begin
         k++;
         md(F_MFLO, '0, '0);
      end while (s_stall && k < 50);
      chk("mflo_release_cycle", 64'(k), 64'd34);
      chk("mflo_value", 64'(s_mdout), 64'd45);

      md(F_MTHI, 32'h0000_AAAA, '0);
      md(F_MTLO, 32'h0000_5555, '0);
`ifdef ALU_DIV_EN
      md(F_DIV, 32'd1000, 32'd3);
`else
      md(F_MULT, 32'd1000, 32'd3);
`endif
      for (int i = 1; i < 10; i++) idle();
      cycle(1'b0, 2'b00, 6'd0, 1'b0, '0, '0, 1'b1);
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (s_done) dcount++;
      end
      chk("abort_no_done", 64'(dcount), 64'd0);

`ifndef ALU_DIV_EN
      md(F_MTHI, 32'h0000_1234, '0);
      md(F_DIV, 32'd9, 32'd3);
      #1;
      chk("nodiv_illegal", 64'(illegal), 64'd1);
      chk("nodiv_ctr", 64'(aluCtr), 64'hF);
      chk("nodiv_busy", 64'(busy), 64'd0);
      chk("nodiv_hi", 64'(hi), 64'h1234);
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
         else fn = fn_list[$urandom_range(0, 17)];
         cycle(($urandom_range(0, 299) != 0), 2'($urandom_range(0, 3) == 0 ? $urandom : 2),
               fn, 1'($urandom_range(0, 3) != 0), rnd_opnd(), rnd_opnd(), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
